// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: two-group signal phase sequencer with blinking-yellow
// night mode, live editing of green/yellow durations and pedestrian
// truncation of the running green.
module traffic_phase_sched #(
    parameter int CNT_WIDTH  = 11,
    parameter int RG_DEFAULT = 8,
    parameter int Y_DEFAULT  = 6,
    parameter int AR_TIME    = 1,
    parameter int MIN_GREEN  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_1s_i,
    input  logic [1:0]           mode_i,
    input  logic                 key_plus_i,
    input  logic                 key_sub_i,
    input  logic                 ped_req1_i,
    input  logic                 ped_req2_i,
    output logic [2:0]           phase_o,
    output logic [5:0]           lamps_o,
    output logic [CNT_WIDTH-1:0] remain_o,
    output logic [CNT_WIDTH-1:0] disp_val_o,
    output logic [CNT_WIDTH-1:0] rg_time_o,
    output logic [CNT_WIDTH-1:0] y_time_o,
    output logic                 phase_start_o,
    output logic                 ped_ack1_o,
    output logic                 ped_ack2_o
);

    typedef enum logic [2:0] {
        NIGHT = 3'd0,
        G1    = 3'd1,
        Y1    = 3'd2,
        AR12  = 3'd3,
        G2    = 3'd4,
        Y2    = 3'd5,
        AR21  = 3'd6
    } phase_e;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_SET_G = 2'b10;
    localparam logic [1:0] MODE_SET_Y = 2'b11;

    localparam logic [CNT_WIDTH-1:0] RG_DEF  = CNT_WIDTH'(RG_DEFAULT);
    localparam logic [CNT_WIDTH-1:0] Y_DEF   = CNT_WIDTH'(Y_DEFAULT);
    localparam logic [CNT_WIDTH-1:0] AR_DUR  = CNT_WIDTH'(AR_TIME);
    localparam logic [CNT_WIDTH-1:0] MIN_G   = CNT_WIDTH'(MIN_GREEN);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // {R1,Y1,G1,R2,Y2,G2}; both yellows lit is the night blink "on" pattern
    localparam logic [5:0] LAMP_NIGHT = 6'b010010;

    function automatic logic [5:0] lamps_for(input phase_e p);
        case (p)
            G1:      return 6'b001100;
            Y1:      return 6'b010100;
            AR12:    return 6'b100100;
            G2:      return 6'b100001;
            Y2:      return 6'b100010;
            AR21:    return 6'b100100;
            default: return LAMP_NIGHT;
        endcase
    endfunction

    phase_e               phase_q;
    logic [5:0]           lamps_q;
    logic [CNT_WIDTH-1:0] remain_q;
    logic [CNT_WIDTH-1:0] rg_time_q, rg_time_d;
    logic [CNT_WIDTH-1:0] y_time_q, y_time_d;
    logic                 ped_lat1_q, ped_lat2_q;
    logic                 phase_start_q, ped_ack1_q, ped_ack2_q;

    phase_e               nxt_phase;
    logic [CNT_WIDTH-1:0] nxt_dur;
    logic [CNT_WIDTH-1:0] edit_val, edit_new;

    // Successor phase and its load value; NIGHT (and AR21) lead into G1.
    always_comb begin
        nxt_phase = G1;
        nxt_dur   = rg_time_q;
        case (phase_q)
            G1:      begin nxt_phase = Y1;   nxt_dur = y_time_q;  end
            Y1:      begin nxt_phase = AR12; nxt_dur = AR_DUR;    end
            AR12:    begin nxt_phase = G2;   nxt_dur = rg_time_q; end
            G2:      begin nxt_phase = Y2;   nxt_dur = y_time_q;  end
            Y2:      begin nxt_phase = AR21; nxt_dur = AR_DUR;    end
            default: begin nxt_phase = G1;   nxt_dur = rg_time_q; end
        endcase
        if (nxt_dur == '0) nxt_dur = ONE;
    end

    // Key editing of the selected duration, saturating at 1 and at full scale.
    always_comb begin
        rg_time_d = rg_time_q;
        y_time_d  = y_time_q;
        edit_val  = (mode_i == MODE_SET_Y) ? y_time_q : rg_time_q;
        edit_new  = edit_val;
        if (key_plus_i && !key_sub_i && edit_val != CNT_MAX)
            edit_new = edit_val + ONE;
        else if (key_sub_i && !key_plus_i)
            edit_new = (edit_val > ONE) ? edit_val - ONE : ONE;
        if (mode_i == MODE_SET_G)
            rg_time_d = edit_new;
        else if (mode_i == MODE_SET_Y)
            y_time_d = edit_new;
    end

    // Duration registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rg_time_q <= RG_DEF;
            y_time_q  <= Y_DEF;
        end else begin
            rg_time_q <= rg_time_d;
            y_time_q  <= y_time_d;
        end
    end

    // Phase sequencer: night override, frozen while editing, countdown and ped truncation in run.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q       <= NIGHT;
            remain_q      <= '0;
            lamps_q       <= LAMP_NIGHT;
            ped_lat1_q    <= 1'b0;
            ped_lat2_q    <= 1'b0;
            phase_start_q <= 1'b0;
            ped_ack1_q    <= 1'b0;
            ped_ack2_q    <= 1'b0;
        end else begin
            phase_start_q <= 1'b0;
            ped_ack1_q    <= 1'b0;
            ped_ack2_q    <= 1'b0;
            if (mode_i == MODE_NIGHT) begin
                phase_q    <= NIGHT;
                remain_q   <= '0;
                ped_lat1_q <= 1'b0;
                ped_lat2_q <= 1'b0;
                if (phase_q != NIGHT)
                    lamps_q <= LAMP_NIGHT;
                else if (tick_1s_i)
                    lamps_q <= lamps_q[4] ? 6'b000000 : LAMP_NIGHT;
            end else if (mode_i == MODE_RUN) begin
                case (phase_q)
                    NIGHT: begin
                        phase_q       <= nxt_phase;
                        remain_q      <= nxt_dur;
                        lamps_q       <= lamps_for(nxt_phase);
                        phase_start_q <= 1'b1;
                        ped_lat1_q    <= ped_lat1_q | ped_req1_i;
                        ped_lat2_q    <= ped_lat2_q | ped_req2_i;
                    end
                    G1, Y1, AR12, G2, Y2, AR21: begin
                        if (tick_1s_i) begin
                            if (remain_q > ONE) begin
                                remain_q   <= remain_q - ONE;
                                // a request seen on a tick is kept for the next non-tick cycle
                                ped_lat1_q <= ped_lat1_q | ped_req1_i;
                                ped_lat2_q <= ped_lat2_q | ped_req2_i;
                            end else begin
                                phase_q       <= nxt_phase;
                                remain_q      <= nxt_dur;
                                lamps_q       <= lamps_for(nxt_phase);
                                phase_start_q <= 1'b1;
                                ped_lat1_q    <= (phase_q == G1) ? 1'b0 : (ped_lat1_q | ped_req1_i);
                                ped_lat2_q    <= (phase_q == G2) ? 1'b0 : (ped_lat2_q | ped_req2_i);
                            end
                        end else begin
                            if (phase_q == G1) begin
                                if ((ped_lat1_q || ped_req1_i) && remain_q > MIN_G) begin
                                    remain_q   <= MIN_G;
                                    ped_ack1_q <= 1'b1;
                                end
                                ped_lat1_q <= 1'b0;
                            end else begin
                                ped_lat1_q <= ped_lat1_q | ped_req1_i;
                            end
                            if (phase_q == G2) begin
                                if ((ped_lat2_q || ped_req2_i) && remain_q > MIN_G) begin
                                    remain_q   <= MIN_G;
                                    ped_ack2_q <= 1'b1;
                                end
                                ped_lat2_q <= 1'b0;
                            end else begin
                                ped_lat2_q <= ped_lat2_q | ped_req2_i;
                            end
                        end
                    end
                    default: begin
                        phase_q  <= NIGHT;
                        remain_q <= '0;
                        lamps_q  <= 6'b000000;
                    end
                endcase
            end
        end
    end

    // Display source follows the key/mode front end.
    always_comb begin
        case (mode_i)
            MODE_RUN:   disp_val_o = remain_q;
            MODE_SET_G: disp_val_o = rg_time_q;
            MODE_SET_Y: disp_val_o = y_time_q;
            default:    disp_val_o = '0;
        endcase
    end

    assign phase_o       = phase_q;
    assign lamps_o       = lamps_q;
    assign remain_o      = remain_q;
    assign rg_time_o     = rg_time_q;
    assign y_time_o      = y_time_q;
    assign phase_start_o = phase_start_q;
    assign ped_ack1_o    = ped_ack1_q;
    assign ped_ack2_o    = ped_ack2_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Testbench for traffic_phase_sched: reference model feeds a scoreboard queue,
// plus directed checks at the scenario boundaries.
module tb_traffic_phase_sched;

    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          plus = 1'b0, sub = 1'b0, r1 = 1'b0, r2 = 1'b0;
    logic [2:0]    phase;
    logic [5:0]    lamps;
    logic [CW-1:0] remain, disp_val, rg_time, y_time;
    logic          phase_start, ack1, ack2;

    traffic_phase_sched #(.CNT_WIDTH(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tick_1s_i    (tick),
        .mode_i       (mode),
        .key_plus_i   (plus),
        .key_sub_i    (sub),
        .ped_req1_i   (r1),
        .ped_req2_i   (r2),
        .phase_o      (phase),
        .lamps_o      (lamps),
        .remain_o     (remain),
        .disp_val_o   (disp_val),
        .rg_time_o    (rg_time),
        .y_time_o     (y_time),
        .phase_start_o(phase_start),
        .ped_ack1_o   (ack1),
        .ped_ack2_o   (ack2)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    string scen = "rst";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s.%s: observed %0d expected %0d", scen, tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int phase, remain, lamps, start, a1, a2, rg, y, disp;
    } snap_t;

    snap_t exp_q[$];

    int lamp_tab [0:6] = '{18, 12, 20, 36, 33, 34, 36};
    int m_phase, m_remain, m_lamps, m_rg, m_y, m_l1, m_l2, m_start, m_a1, m_a2;

    task automatic model_reset();
        m_phase = 0; m_remain = 0; m_lamps = 18; m_rg = 8; m_y = 6;
        m_l1 = 0; m_l2 = 0; m_start = 0; m_a1 = 0; m_a2 = 0;
    endtask

    task automatic model_load(input int p);
        int d;
        if (p == 1 || p == 4)      d = m_rg;
        else if (p == 2 || p == 5) d = m_y;
        else                       d = 1;
        m_phase  = p;
        m_remain = (d == 0) ? 1 : d;
        m_lamps  = lamp_tab[p];
        m_start  = 1;
    endtask

    task automatic model_step(input int t, input int md, input int p, input int s, input int q1, input int q2);
        int v, old;
        m_start = 0; m_a1 = 0; m_a2 = 0;
        if (md == 1) begin
            if (m_phase != 0)  m_lamps = 18;
            else if (t != 0)   m_lamps = (m_lamps == 18) ? 0 : 18;
            m_phase = 0; m_remain = 0; m_l1 = 0; m_l2 = 0;
        end else if (md >= 2) begin
            v = (md == 2) ? m_rg : m_y;
            if (p != 0 && s == 0)      v = (v + 1 > 2047) ? 2047 : v + 1;
            else if (s != 0 && p == 0) v = (v - 1 < 1) ? 1 : v - 1;
            if (md == 2) m_rg = v; else m_y = v;
        end else if (m_phase == 0) begin
            model_load(1);
            m_l1 = m_l1 | q1; m_l2 = m_l2 | q2;
        end else if (t != 0) begin
            if (m_remain > 1) begin
                m_remain--;
                m_l1 = m_l1 | q1; m_l2 = m_l2 | q2;
            end else begin
                old = m_phase;
                model_load((old == 6) ? 1 : old + 1);
                m_l1 = (old == 1) ? 0 : (m_l1 | q1);
                m_l2 = (old == 4) ? 0 : (m_l2 | q2);
            end
        end else begin
            if (m_phase == 1) begin
                if ((m_l1 | q1) != 0 && m_remain > 3) begin m_remain = 3; m_a1 = 1; end
                m_l1 = 0;
            end else m_l1 = m_l1 | q1;
            if (m_phase == 4) begin
                if ((m_l2 | q2) != 0 && m_remain > 3) begin m_remain = 3; m_a2 = 1; end
                m_l2 = 0;
            end else m_l2 = m_l2 | q2;
        end
    endtask

    function automatic snap_t snap_now(input int md);
        snap_t e;
        e.phase = m_phase; e.remain = m_remain; e.lamps = m_lamps;
        e.start = m_start; e.a1 = m_a1; e.a2 = m_a2; e.rg = m_rg; e.y = m_y;
        case (md)
            0:       e.disp = m_remain;
            2:       e.disp = m_rg;
            3:       e.disp = m_y;
            default: e.disp = 0;
        endcase
        return e;
    endfunction

    // one clock: drive, predict, clock, compare at the falling edge
    task automatic step(input bit t, input bit p, input bit s, input bit q1, input bit q2);
        snap_t e;
        tick = t; plus = p; sub = s; r1 = q1; r2 = q2;
        model_step(int'(t), int'(mode), int'(p), int'(s), int'(q1), int'(q2));
        exp_q.push_back(snap_now(int'(mode)));
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("phase",  32'(phase),       e.phase);
        chk("remain", 32'(remain),      e.remain);
        chk("lamps",  32'(lamps),       e.lamps);
        chk("start",  32'(phase_start), e.start);
        chk("ack1",   32'(ack1),        e.a1);
        chk("ack2",   32'(ack2),        e.a2);
        chk("rg",     32'(rg_time),     e.rg);
        chk("y",      32'(y_time),      e.y);
        chk("disp",   32'(disp_val),    e.disp);
        tick = 0; plus = 0; sub = 0; r1 = 0; r2 = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            step(1, 0, 0, 0, 0);
        end
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < 60 && m_phase != p; i++) begin
            idle();
            step(1, 0, 0, 0, 0);
        end
        chk("run_to", 32'(phase), p);
    endtask

    int seq_next [0:5] = '{2, 3, 4, 5, 6, 1};
    int seq_dur  [0:5] = '{8, 6, 1, 8, 6, 1};

    initial begin
        rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("phase",  32'(phase),       0);
        chk("remain", 32'(remain),      0);
        chk("lamps",  32'(lamps),       32'h12);
        chk("rg",     32'(rg_time),     8);
        chk("y",      32'(y_time),      6);
        chk("start",  32'(phase_start), 0);
        chk("acks",   32'({ack1, ack2}), 0);
        @(negedge clk);
        rst = 1'b0;

        // full cycle with default durations
        scen = "s1";
        idle();
        chk("g1_load", 32'(remain), 8);
        for (int k = 0; k < 6; k++) begin
            ticks(seq_dur[k]);
            chk("seq", 32'(phase), seq_next[k]);
        end

        // night mode entered mid-G2
        scen = "s2";
        ticks(15);
        chk("g2", 32'(phase), 4);
        ticks(3);
        chk("g2_rem5", 32'(remain), 5);
        mode = 2'b01;
        idle();
        chk("night_ph", 32'(phase), 0);
        chk("night_lamps", 32'(lamps), 32'h12);
        for (int i = 0; i < 4; i++) begin
            ticks(1);
            chk("blink", 32'(lamps), (i % 2 == 0) ? 0 : 32'h12);
        end
        mode = 2'b00;
        idle();
        chk("resume_g1", 32'(remain), 8);

        // duration editing
        scen = "s3";
        mode = 2'b10;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        chk("rg11", 32'(rg_time), 11);
        step(0, 1, 1, 0, 0);
        chk("rg_both", 32'(rg_time), 11);
        step(1, 0, 0, 0, 0);
        chk("frozen", 32'(remain), 8);
        mode = 2'b11;
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
        chk("y_sat1", 32'(y_time), 1);
        mode = 2'b00;
        idle();
        chk("held_rem", 32'(remain), 8);
        run_to(4);
        chk("g2_new", 32'(remain), 11);
        mode = 2'b10;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        mode = 2'b11;
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        chk("restore", 32'({rg_time, y_time}), {8'd0, 13'd8, 11'd6});
        mode = 2'b00;

        // ped request for group 1 latched during G2
        scen = "s4";
        step(0, 0, 0, 1, 0);
        run_to(1);
        chk("g1_load", 32'(remain), 8);
        idle();
        chk("trunc", 32'(remain), 3);
        chk("ack1", 32'(ack1), 1);
        idle();
        chk("ack1_once", 32'(ack1), 0);
        ticks(1);
        step(0, 0, 0, 1, 0);
        chk("late_rem", 32'(remain), 2);
        chk("late_ack", 32'(ack1), 0);
        ticks(1);
        chk("still_g1", 32'(phase), 1);
        ticks(1);
        chk("to_y1", 32'(phase), 2);

        // tick and ped request on the same cycle
        scen = "s5";
        run_to(4);
        ticks(2);
        chk("rem6", 32'(remain), 6);
        step(1, 0, 0, 0, 1);
        chk("tick_first", 32'(remain), 5);
        chk("no_ack_yet", 32'(ack2), 0);
        idle();
        chk("trunc", 32'(remain), 3);
        chk("ack2", 32'(ack2), 1);

        // asynchronous reset mid-Y1
        scen = "s6";
        mode = 2'b10;
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
        chk("rg20", 32'(rg_time), 20);
        mode = 2'b00;
        run_to(2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("phase",  32'(phase),       0);
        chk("rg",     32'(rg_time),     8);
        chk("lamps",  32'(lamps),       32'h12);
        chk("start",  32'(phase_start), 0);
        chk("remain", 32'(remain),      0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk("restart", 32'(remain), 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
